spike_time_decoder: RTL and testbench

- Sits at the output end of the TTFS dense-layer chain and reads the final layer's spike-time vector through the same valid/ready parallel-bus handshake.
- Scans one element per cycle to find the earliest spike, i.e. the minimum signed time; that element is the winning class.
- Reports the class index, its spike time, the margin to the second-earliest spike, and a no-spike flag.
- The result is held until the downstream consumer accepts it.

---
 rtl/spike_time_decoder_if.sv | 27 ++
 rtl/spike_time_decoder.sv | 110 +++++++++++
 tb/tb_spike_time_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spike_time_decoder_if.sv
// Valid/ready bus between the last TTFS layer, the spike-time decoder and its result consumer.
// master = the side that drives the vector and accepts results; slave = the decoder.
interface spike_time_decoder_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
);
  logic                              i_valid;
  logic                              i_ready;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_spikes;
  logic                              o_valid;
  logic                              o_ready;
  logic [IDX_WIDTH-1:0]              o_class;
  logic [DATA_WIDTH-1:0]             o_time;
  logic [DATA_WIDTH-1:0]             o_margin;
  logic                              o_no_spike;

  modport master (
    output i_valid, i_spikes, o_ready,
    input  i_ready, o_valid, o_class, o_time, o_margin, o_no_spike
  );

  modport slave (
    input  i_valid, i_spikes, o_ready,
    output i_ready, o_valid, o_class, o_time, o_margin, o_no_spike
  );
endinterface

// File: rtl/spike_time_decoder.sv
// Earliest-spike decoder: scans one captured spike time per cycle, keeping the two smallest
// signed times, then presents winner index, time, margin and no-spike flag until accepted.
module spike_time_decoder #(
  parameter int                    NUM_CLASSES = 10,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] T_MAX       = 32'h00020000,
  parameter int                    IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input logic                  clk,
  input logic                  rst_n,
  spike_time_decoder_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam logic signed [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [IDX_WIDTH-1:0] LAST_K  = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [IDX_WIDTH-1:0]           k_q, k_d, idx_q, idx_d, cls_q, cls_d;
  logic signed [DW-1:0]           best_q, best_d, second_q, second_d;
  logic signed [DW-1:0]           time_q, time_d, margin_q, margin_d;
  logic                           ns_q, ns_d;
  logic [NUM_CLASSES-1:0][DW-1:0] spk_q, spk_d;
  logic signed [DW-1:0]           t;
  logic signed [DW:0]             diff;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    idx_d    = idx_q;
    best_d   = best_q;
    second_d = second_q;
    spk_d    = spk_q;
    cls_d    = cls_q;
    time_d   = time_q;
    margin_d = margin_q;
    ns_d     = ns_q;
    t        = spk_q[k_q];
    diff     = '0;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        spk_d    = bus.i_spikes;
        k_d      = '0;
        idx_d    = '0;
        best_d   = MAX_POS;
        second_d = MAX_POS;
        state_d  = SCAN;
      end
      SCAN: begin
        // Strict less-than keeps the lower index on ties and pushes the tie into second.
        if (t < best_q) begin
          second_d = best_q;
          best_d   = t;
          idx_d    = k_q;
        end else if (t < second_q) begin
          second_d = t;
        end
        if (k_q == LAST_K) begin
          state_d = DONE;
          cls_d   = idx_d;
          time_d  = best_d;
          ns_d    = (best_d >= $signed(T_MAX));
          diff    = {second_d[DW-1], second_d} - {best_d[DW-1], best_d};
          // second >= best always, so only positive overflow needs clamping.
          if (diff[DW])        margin_d = '0;
          else if (diff[DW-1]) margin_d = MAX_POS;
          else                 margin_d = diff[DW-1:0];
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: if (bus.o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      idx_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      spk_q    <= '0;
      cls_q    <= '0;
      time_q   <= '0;
      margin_q <= '0;
      ns_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      second_q <= second_d;
      spk_q    <= spk_d;
      cls_q    <= cls_d;
      time_q   <= time_d;
      margin_q <= margin_d;
      ns_q     <= ns_d;
    end
  end

  assign bus.i_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_class    = cls_q;
  assign bus.o_time     = time_q;
  assign bus.o_margin   = margin_q;
  assign bus.o_no_spike = ns_q;
endmodule

// File: tb/tb_spike_time_decoder.sv
// Bench for spike_time_decoder with 4 classes: table of vectors with hand-derived results,
// queued at acceptance and compared when o_valid rises, plus reset and backpressure sequences.
module tb_spike_time_decoder;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [N-1:0][DW-1:0] spikes;
    logic [IW-1:0]        exp_class;
    logic [DW-1:0]        exp_time;
    logic [DW-1:0]        exp_margin;
    logic                 exp_ns;
    int                   hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[7];
  vec_t exp_q[$];

  spike_time_decoder_if #(.NUM_CLASSES(N), .DATA_WIDTH(DW)) bus();

  spike_time_decoder #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .T_MAX(32'h00020000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] e0, e1, e2, e3,
                              input logic [IW-1:0] c, input logic [DW-1:0] t, m,
                              input logic ns, input int hold);
    vec_t v;
    v.spikes     = {e3, e2, e1, e0};
    v.exp_class  = c;
    v.exp_time   = t;
    v.exp_margin = m;
    v.exp_ns     = ns;
    v.hold       = hold;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_o_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_i_ready"}, 64'(bus.i_ready), 64'd1);
    chk({tag, "_outs"}, {bus.o_margin, bus.o_time} | 64'(bus.o_class) | 64'(bus.o_no_spike), 64'd0);
  endtask

  // Called at a negedge; drives the vector and returns at the negedge after acceptance.
  task automatic drive(input vec_t v);
    int w = 0;
    bus.i_spikes = v.spikes;
    bus.i_valid  = 1'b1;
    while (!bus.i_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 64'(w >= 50), 64'd0);
    @(posedge clk);
    exp_q.push_back(v);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // Called at a negedge; runs one full transaction and returns at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int   n = 0;
    drive(v);
    while (!bus.o_valid && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(n + 0), 64'(N));
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_class"},    64'(bus.o_class),    64'(e.exp_class));
    chk({tag, "_time"},     64'(bus.o_time),     64'(e.exp_time));
    chk({tag, "_margin"},   64'(bus.o_margin),   64'(e.exp_margin));
    chk({tag, "_no_spike"}, 64'(bus.o_no_spike), 64'(e.exp_ns));
    if (e.hold > 0) begin
      bus.o_ready  = 1'b0;
      bus.i_spikes = tbl[0].spikes;
      bus.i_valid  = 1'b1;
      for (int h = 0; h < e.hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
        chk({tag, "_hold_iready"}, 64'(bus.i_ready), 64'd0);
        chk({tag, "_hold_time"}, 64'(bus.o_time), 64'(e.exp_time));
        chk({tag, "_hold_margin"}, 64'(bus.o_margin), 64'(e.exp_margin));
      end
      bus.i_valid = 1'b0;
      bus.o_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_after_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_after_iready"}, 64'(bus.i_ready), 64'd1);
    chk({tag, "_after_class"}, 64'(bus.o_class), 64'(e.exp_class));
  endtask

  initial begin
    tbl[0] = mk(32'h18000, 32'h12000, 32'h1F000, 32'h15000, 2'd1, 32'h12000, 32'h3000, 1'b0, 0);
    tbl[1] = mk(32'h14000, 32'h11000, 32'h11000, 32'h16000, 2'd1, 32'h11000, 32'h0, 1'b0, 0);
    tbl[2] = mk(32'h20000, 32'h20000, 32'h20000, 32'h20000, 2'd0, 32'h20000, 32'h0, 1'b1, 0);
    tbl[3] = mk(32'h5000, 32'hFFFFF000, 32'h30000, 32'hFFFFE000, 2'd3, 32'hFFFFE000, 32'h1000, 1'b0, 0);
    tbl[4] = mk(32'h20001, 32'h20000, 32'h7FFFFFFF, 32'h20002, 2'd1, 32'h20000, 32'h1, 1'b1, 0);
    tbl[5] = mk(32'h1F000, 32'h2A000, 32'h30000, 32'h1FFFF, 2'd0, 32'h1F000, 32'hFFF, 1'b0, 10);
    tbl[6] = mk(32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 2'd0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 0);

    bus.i_valid  = 1'b0;
    bus.i_spikes = '0;
    bus.o_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("idle5");

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset during SCAN discards the scan and clears the held results.
    drive(tbl[3]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midscan_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(tbl[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
